// File: rtl/lil_me_pkg.sv
// Shared constants, state type and size helpers for the lil_me matrix engine.
package lil_me_pkg;

    localparam logic [2:0] OP_IDLE      = 3'b000;
    localparam logic [2:0] OP_LOAD_ADDR = 3'b001;
    localparam logic [2:0] OP_LOAD_A    = 3'b010;
    localparam logic [2:0] OP_LOAD_B    = 3'b011;
    localparam logic [2:0] OP_MUL       = 3'b101;
    localparam logic [2:0] OP_READ_C    = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Number of words in A (row x col) or B (col x row).
    function automatic int ab_size(input int r, input int c);
        return r * c;
    endfunction

    // Number of words in C (row x row).
    function automatic int c_size(input int r);
        return r * r;
    endfunction

    // Index width for an n-entry array, never narrower than one bit.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lil_me_dot.sv
// Combinational dot product of one A row with one B column, wrapping to the word width.
module lil_me_dot #(
    parameter int dw  = 31,
    parameter int col = 4
) (
    input  logic [col*(dw+1)-1:0] i_a_vec,
    input  logic [col*(dw+1)-1:0] i_b_vec,
    output logic [dw:0]           o_dot
);

    // col independent multipliers summed together; products and sum both wrap modulo 2^(dw+1)
    always_comb begin
        o_dot = '0;
        for (int k = 0; k < col; k++) begin
            o_dot = o_dot + i_a_vec[k*(dw+1) +: (dw+1)] * i_b_vec[k*(dw+1) +: (dw+1)];
        end
    end

endmodule

// File: rtl/lil_me.sv
// lil_me: register-file matrix engine. Loads A and B word by word, computes
// C = A x B one element per cycle, and streams C back out on request.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | accepts one command per cycle (load addr/A/B, read C, MUL)
// ST_MUL  | writes one C element per cycle; all commands ignored
module lil_me
    import lil_me_pkg::*;
#(
    parameter int dw  = 31,
    parameter int aw  = 31,
    parameter int row = 4,
    parameter int col = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    ME_opcode,
    input  logic          A_opcode,
    input  logic          B_opcode,
    output logic [aw:0]   Address_out,
    input  logic [dw:0]   Data_in,
    output logic          Busy,
    output logic [dw:0]   Data_out,
    output logic [dw:0]   result
);

    localparam int AB_N = ab_size(row, col);
    localparam int C_N  = c_size(row);
    localparam int AIW  = idx_bits(AB_N);
    localparam int CIW  = idx_bits(C_N);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_busy;

    logic [aw:0]        r_base;
    logic [AIW-1:0]     r_a_idx;
    logic [AIW-1:0]     r_b_idx;
    logic [CIW-1:0]     r_c_idx;
    logic [dw:0]        r_a [AB_N];
    logic [dw:0]        r_b [AB_N];
    logic [dw:0]        r_c [C_N];
    logic [aw:0]        r_addr_out;
    logic [dw:0]        r_data_out;
    logic [dw:0]        r_result;

    logic               w_c_last;
    logic [CIW-1:0]     w_row_i;
    logic [CIW-1:0]     w_col_j;
    logic [col*(dw+1)-1:0] w_a_vec;
    logic [col*(dw+1)-1:0] w_b_vec;
    logic [dw:0]        w_dot;

    assign w_c_last = (r_c_idx == CIW'(C_N - 1));
    assign w_row_i  = r_c_idx / CIW'(row);
    assign w_col_j  = r_c_idx % CIW'(row);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and Busy decode
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ME_opcode == OP_MUL) begin
                    w_next_state = ST_MUL;
                end
            end
            ST_MUL: begin
                w_busy = 1'b1;
                if (w_c_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Gather row i of A and column j of B for the element currently being computed
    always_comb begin
        w_a_vec = '0;
        w_b_vec = '0;
        for (int k = 0; k < col; k++) begin
            w_a_vec[k*(dw+1) +: (dw+1)] = r_a[AIW'(int'(w_row_i) * col + k)];
            w_b_vec[k*(dw+1) +: (dw+1)] = r_b[AIW'(k * row + int'(w_col_j))];
        end
    end

    lil_me_dot #(
        .dw  (dw),
        .col (col)
    ) u_dot (
        .i_a_vec (w_a_vec),
        .i_b_vec (w_b_vec),
        .o_dot   (w_dot)
    );

    // Register files, indices and output registers; commands act only in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base     <= '0;
            r_a_idx    <= '0;
            r_b_idx    <= '0;
            r_c_idx    <= '0;
            r_a        <= '{default: '0};
            r_b        <= '{default: '0};
            r_c        <= '{default: '0};
            r_addr_out <= '0;
            r_data_out <= '0;
            r_result   <= '0;
        end else if (r_state == ST_MUL) begin
            r_c[r_c_idx] <= w_dot;
            r_result     <= w_dot;
            r_addr_out   <= r_base + (aw+1)'(r_c_idx);
            r_c_idx      <= w_c_last ? '0 : r_c_idx + 1'b1;
        end else begin
            case (ME_opcode)
                OP_IDLE: ;
                OP_LOAD_ADDR: begin
                    r_base     <= (aw+1)'(Data_in);
                    r_addr_out <= (aw+1)'(Data_in);
                    r_a_idx    <= '0;
                    r_b_idx    <= '0;
                    r_c_idx    <= '0;
                end
                OP_LOAD_A: begin
                    if (A_opcode) begin
                        r_a[r_a_idx] <= Data_in;
                        r_addr_out   <= r_base + (aw+1)'(r_a_idx);
                        r_a_idx      <= (r_a_idx == AIW'(AB_N - 1)) ? '0 : r_a_idx + 1'b1;
                    end
                end
                OP_LOAD_B: begin
                    if (B_opcode) begin
                        r_b[r_b_idx] <= Data_in;
                        r_addr_out   <= r_base + (aw+1)'(r_b_idx);
                        r_b_idx      <= (r_b_idx == AIW'(AB_N - 1)) ? '0 : r_b_idx + 1'b1;
                    end
                end
                OP_MUL: begin
                    r_c_idx <= '0;
                end
                OP_READ_C: begin
                    r_data_out <= r_c[r_c_idx];
                    r_addr_out <= r_base + (aw+1)'(r_c_idx);
                    r_c_idx    <= w_c_last ? '0 : r_c_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Busy        = w_busy;
    assign Address_out = r_addr_out;
    assign Data_out    = r_data_out;
    assign result      = r_result;

endmodule

// File: tb/tb_lil_me.sv
// Scoreboard bench for lil_me: a matrix-level reference model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_lil_me;

    localparam int DW  = 31;
    localparam int AW  = 31;
    localparam int ROW = 4;
    localparam int COL = 4;
    localparam int NA  = ROW * COL;
    localparam int NC  = ROW * ROW;

    localparam logic [2:0] C_IDLE  = 3'b000;
    localparam logic [2:0] C_LADDR = 3'b001;
    localparam logic [2:0] C_LA    = 3'b010;
    localparam logic [2:0] C_LB    = 3'b011;
    localparam logic [2:0] C_MUL   = 3'b101;
    localparam logic [2:0] C_RDC   = 3'b111;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    ME_opcode;
    logic          A_opcode;
    logic          B_opcode;
    logic [AW:0]   Address_out;
    logic [DW:0]   Data_in;
    logic          Busy;
    logic [DW:0]   Data_out;
    logic [DW:0]   result;

    lil_me #(.dw(DW), .aw(AW), .row(ROW), .col(COL)) dut (
        .clk         (clk),
        .reset       (reset),
        .ME_opcode   (ME_opcode),
        .A_opcode    (A_opcode),
        .B_opcode    (B_opcode),
        .Address_out (Address_out),
        .Data_in     (Data_in),
        .Busy        (Busy),
        .Data_out    (Data_out),
        .result      (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW:0] addr;
        logic [DW:0] dout;
        logic [DW:0] res;
        logic        busy;
        bit          chk_addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: matrices as plain arrays, MUL finishes the whole
    // product up front and reveals one element per cycle.
    logic [DW:0] m_a[];
    logic [DW:0] m_b[];
    logic [DW:0] m_c[];
    logic [DW:0] m_prod[];
    logic [AW:0] m_base, m_addr;
    logic [DW:0] m_dout, m_res;
    int          m_aidx, m_bidx, m_cidx, m_left;
    bit          m_addr_ok;

    task automatic model_reset();
        foreach (m_a[k]) m_a[k] = '0;
        foreach (m_b[k]) m_b[k] = '0;
        foreach (m_c[k]) m_c[k] = '0;
        m_base = '0; m_addr = '0; m_dout = '0; m_res = '0;
        m_aidx = 0; m_bidx = 0; m_cidx = 0; m_left = 0;
        m_addr_ok = 1'b1;
    endtask

    task automatic model_matmul();
        for (int i = 0; i < ROW; i++) begin
            for (int j = 0; j < ROW; j++) begin
                logic [DW:0] s;
                s = '0;
                for (int k = 0; k < COL; k++) s = s + m_a[i*COL+k] * m_b[k*ROW+j];
                m_prod[i*ROW+j] = s;
            end
        end
    endtask

    task automatic model_edge(input logic [2:0] op, input logic ao, input logic bo,
                              input logic [DW:0] din);
        if (m_left > 0) begin
            int n;
            n = NC - m_left;
            m_c[n] = m_prod[n];
            m_res  = m_prod[n];
            m_left--;
            if (m_left == 0) m_cidx = 0;
        end else begin
            case (op)
                C_LADDR: begin
                    m_base = din; m_addr = din; m_addr_ok = 1'b1;
                    m_aidx = 0; m_bidx = 0; m_cidx = 0;
                end
                C_LA: if (ao) begin
                    m_a[m_aidx] = din;
                    m_addr = m_base + (AW+1)'(m_aidx); m_addr_ok = 1'b1;
                    m_aidx = (m_aidx + 1) % NA;
                end
                C_LB: if (bo) begin
                    m_b[m_bidx] = din;
                    m_addr = m_base + (AW+1)'(m_bidx); m_addr_ok = 1'b1;
                    m_bidx = (m_bidx + 1) % NA;
                end
                C_MUL: begin
                    model_matmul();
                    m_left = NC; m_cidx = 0; m_addr_ok = 1'b0;
                end
                C_RDC: begin
                    m_dout = m_c[m_cidx];
                    m_addr = m_base + (AW+1)'(m_cidx); m_addr_ok = 1'b1;
                    m_cidx = (m_cidx + 1) % NC;
                end
                default: ;
            endcase
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.addr = m_addr; e.dout = m_dout; e.res = m_res;
        e.busy = (m_left > 0); e.chk_addr = m_addr_ok;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [2:0] op, input logic ao, input logic bo, input logic [DW:0] din);
        ME_opcode = op; A_opcode = ao; B_opcode = bo; Data_in = din;
        @(posedge clk);
        model_edge(op, ao, bo, din);
        push_exp();
        #1;
    endtask

    task automatic rand_step();
        step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        ME_opcode = C_IDLE; A_opcode = 1'b0; B_opcode = 1'b0; Data_in = '0;
        model_reset();
        push_exp();
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: one expectation per clock, compared away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            n_cmp++;
            if (Busy !== e_mon.busy) begin
                n_bad++;
                $display("FAIL busy @%0t: got %0b want %0b", $time, Busy, e_mon.busy);
            end
            n_cmp++;
            if (result !== e_mon.res) begin
                n_bad++;
                $display("FAIL result @%0t: got %h want %h", $time, result, e_mon.res);
            end
            n_cmp++;
            if (Data_out !== e_mon.dout) begin
                n_bad++;
                $display("FAIL data_out @%0t: got %h want %h", $time, Data_out, e_mon.dout);
            end
            if (e_mon.chk_addr) begin
                n_cmp++;
                if (Address_out !== e_mon.addr) begin
                    n_bad++;
                    $display("FAIL address_out @%0t: got %h want %h", $time, Address_out, e_mon.addr);
                end
            end
        end
    end

    initial begin
        m_a = new[NA]; m_b = new[NA]; m_c = new[NC]; m_prod = new[NC];
        ME_opcode = C_IDLE; A_opcode = 1'b0; B_opcode = 1'b0; Data_in = '0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_reset();
        push_exp();
        @(negedge clk);
        #1;
        reset = 1'b1;

        // Directed: base 0x100, A = 0..15, B = 1..16
        step(C_LADDR, 1'b0, 1'b0, 32'h100);
        for (int k = 0; k < NA; k++) step(C_LA, 1'b1, 1'b0, 32'(k));
        for (int k = 0; k < 3; k++) step(C_LA, 1'b0, 1'b0, 32'hDEAD_0000 + 32'(k));
        for (int k = 0; k < NA; k++) step(C_LB, 1'b0, 1'b1, 32'(k + 1));
        for (int k = 0; k < 3; k++) step(C_LB, 1'b1, 1'b0, 32'hBEEF_0000 + 32'(k));
        step(C_MUL, 1'b0, 1'b0, '0);
        for (int k = 0; k < NC; k++) rand_step();
        for (int k = 0; k < NC + 1; k++) step(C_RDC, 1'b0, 1'b0, '0);

        // Overflow: all-ones operands
        step(C_LADDR, 1'b0, 1'b0, 32'h200);
        for (int k = 0; k < NA; k++) step(C_LA, 1'b1, 1'b0, 32'hFFFF_FFFF);
        for (int k = 0; k < NA; k++) step(C_LB, 1'b0, 1'b1, 32'hFFFF_FFFF);
        step(C_MUL, 1'b0, 1'b0, '0);
        for (int k = 0; k < NC; k++) rand_step();
        for (int k = 0; k < NC; k++) step(C_RDC, 1'b0, 1'b0, '0);

        // Partial loads on top of existing contents, then MUL held past completion
        for (int k = 0; k < 5; k++) step(C_LA, 1'b1, 1'b0, $urandom());
        for (int k = 0; k < 7; k++) step(C_LB, 1'b0, 1'b1, $urandom());
        for (int k = 0; k < 40; k++) step(C_MUL, 1'b0, 1'b0, $urandom());
        for (int k = 0; k < NC; k++) step(C_RDC, 1'b0, 1'b0, '0);

        // Random command stream
        for (int k = 0; k < 400; k++) rand_step();
        for (int k = 0; k < NC + 2; k++) step(C_IDLE, 1'b0, 1'b0, '0);

        // Reset mid-MUL clears C
        step(C_MUL, 1'b0, 1'b0, '0);
        for (int k = 0; k < 5; k++) step(C_IDLE, 1'b0, 1'b0, '0);
        do_reset();
        for (int k = 0; k < NC; k++) step(C_RDC, 1'b0, 1'b0, '0);

        step(C_IDLE, 1'b0, 1'b0, '0);
        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lil_me.md
# lil_me

Small matrix engine: two register-file matrices A (row×col) and B (col×row) are loaded one word per cycle from a shared data bus, multiplied into C (row×row), and C is read back one word per cycle. It sits as a memory-mapped coprocessor beside a host that drives a 3-bit command opcode and polls `Busy`. `Address_out` tells the host which word address the current transfer targets.

## Interface
- `dw`, 31: data MSB index (word = dw+1 bits).
- `aw`, 31: address MSB index.
- `row`, 4: rows of A, rows/cols of C.
- `col`, 4: cols of A, rows of B.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `ME_opcode` in 3: command (000 IDLE, 001 LOAD_ADDR, 010 LOAD_A, 011 LOAD_B, 101 MUL, 111 READ_C; 100/110 reserved = IDLE).
- `A_opcode` in 1: write-enable qualifier for LOAD_A.
- `B_opcode` in 1: write-enable qualifier for LOAD_B.
- `Address_out` out aw+1: base + current element index.
- `Data_in` in dw+1: load data / base address.
- `Busy` out 1: high while MUL computes.
- `Data_out` out dw+1: C element read by READ_C.
- `result` out dw+1: most recently computed C element.

## Operation
- States: IDLE, MUL. All commands other than MUL execute in IDLE, one per cycle; opcode sampled each rising edge.
- LOAD_ADDR: base <= `Data_in`; a_idx, b_idx, c_idx <= 0.
- LOAD_A (with `A_opcode`=1): A[a_idx] <= `Data_in` (row-major); a_idx increments, wraps row*col-1 -> 0. Without `A_opcode`: no-op.
- LOAD_B (with `B_opcode`=1): same into B with b_idx (row-major, col×row).
- MUL: enter MUL; c_idx <= 0. Each cycle compute one C[i][j] = Σk A[i][k]·B[k][j], unsigned, products and sum truncated modulo 2^(dw+1); write C, update `result`. After row*row elements return to IDLE, c_idx <= 0.
- READ_C: `Data_out` <= C[c_idx]; c_idx increments, wraps row*row-1 -> 0.
- `Address_out` = base + index of the transfer last performed (a_idx, b_idx or c_idx as applicable), registered.
- While Busy all opcodes ignored (no loads, no reads, no restart).
- LOAD_A and LOAD_B indices independent; loading fewer than all elements leaves remaining entries unchanged.

## Timing
- Reset: all outputs 0, A/B/C cleared, indices and base 0, state IDLE.
- Loads/reads: one word per cycle, result visible the cycle after the sampling edge; `Busy` stays 0.
- MUL sampled at edge t: `Busy`=1 from t+1 for exactly row*row cycles; C[n] and `result` valid after edge t+1+n; `Busy` drops with last element written.
- Reset asserted mid-MUL aborts immediately; C cleared.
- Holding MUL opcode past completion starts a new MUL (same result).

## Structure
- Package `lil_me_pkg`: opcode constants, state enum, helper `row*col`/`row*row` sizes.
- Sub-module `lil_me_dot`: combinational col-wide dot product (col multipliers + adder tree, truncating to dw+1 bits).

## Test plan
- Reset: assert `reset`=0 -> all outputs 0, `Busy`=0.
- LOAD_ADDR with `Data_in`=0x100 -> next cycle `Address_out`=0x100; indices 0.
- LOAD_A 16 cycles `Data_in`=0..15, `A_opcode`=1 -> `Address_out` steps 0x100..0x10F, `Busy` stays 0; with `A_opcode`=0 nothing written.
- LOAD_B 16 cycles `Data_in`=1..16, then MUL one cycle -> `Busy`=1 for 16 cycles, opcodes during Busy ignored; final `result`=0x230 (560).
- READ_C 16 cycles -> `Data_out` = 0x3E (62), 0x44 (68), …, C[1][0]=0xAE (174), …, last 0x230; 17th read wraps to 0x3E.
- Overflow: A, B all 0xFFFFFFFF -> each C element = 4 mod 2^32 = 0x00000004.
